// File: rtl/probe_detector_mc_if.sv
// Bus bundle for the multi-channel probe detector: run control, probe inputs,
// trigger output and the valid/ready result channel.
interface probe_detector_mc_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                          start;
    logic                          continuous;
    logic                          abort;
    logic [CNT_WIDTH-1:0]          aver_time;
    logic [NUM_CH-1:0]             probe_signal_in;
    logic                          trigger_data_out;
    logic                          busy;
    logic                          result_valid;
    logic                          result_ready;
    logic [NUM_CH*CNT_WIDTH-1:0]   result_data;
    logic                          result_overrun;

    // Environment side: drives control, probes and result acceptance
    modport master (
        output start, continuous, abort, aver_time, probe_signal_in, result_ready,
        input  trigger_data_out, busy, result_valid, result_data, result_overrun
    );

    // Detector side
    modport slave (
        input  start, continuous, abort, aver_time, probe_signal_in, result_ready,
        output trigger_data_out, busy, result_valid, result_data, result_overrun
    );
endinterface

// File: rtl/probe_detector_mc.sv
// Multi-channel probe detector: fires a trigger per trial, waits a settle
// window, samples synchronized probe bits into saturating hit counters and
// publishes the per-channel counts through a valid/ready result register.
module probe_detector_mc #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                shifting_clk,
    input  logic                shifting_rst,
    probe_detector_mc_if.slave  bus
);
    localparam int unsigned SW = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRIG   = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                      state_q;
    logic [NUM_CH-1:0]           sync_q [SYNC_STAGES];
    logic [CNT_WIDTH-1:0]        trial_q;
    logic [SW-1:0]               settle_q;
    logic [CNT_WIDTH-1:0]        hit_q [NUM_CH];
    logic [CNT_WIDTH-1:0]        hit_d [NUM_CH];
    logic                        trig_q;
    logic                        busy_q;
    logic                        valid_q;
    logic                        overrun_q;
    logic [NUM_CH*CNT_WIDTH-1:0] data_q;
    logic [NUM_CH-1:0]           sync_c;
    logic                        hs_c;

    assign sync_c = sync_q[SYNC_STAGES-1];
    assign hs_c   = valid_q & bus.result_ready;

    // Per-channel synchronizer chain; the only consumer of the raw probe pins
    always_ff @(posedge shifting_clk) begin
        if (shifting_rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= bus.probe_signal_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Saturating increment of each hit counter by its synchronized probe bit
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            hit_d[c] = hit_q[c];
            if (sync_c[c] && (hit_q[c] != CNT_MAX)) hit_d[c] = hit_q[c] + CNT_WIDTH'(1);
        end
    end

    // Run sequencer with registered trigger/busy and the result channel
    always_ff @(posedge shifting_clk) begin
        if (shifting_rst) begin
            state_q   <= IDLE;
            trial_q   <= '0;
            settle_q  <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) hit_q[c] <= '0;
        end else begin
            trig_q <= 1'b0;
            if (hs_c) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (bus.abort && (state_q != IDLE)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.abort && (bus.start || bus.continuous)) begin
                            trial_q <= (bus.aver_time == '0) ? CNT_WIDTH'(1) : bus.aver_time;
                            for (int c = 0; c < int'(NUM_CH); c++) hit_q[c] <= '0;
                            state_q <= TRIG;
                            trig_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    TRIG: begin
                        settle_q <= SW'(SETTLE_CYCLES - 1);
                        state_q  <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_q == '0) state_q <= SAMPLE;
                        else                settle_q <= settle_q - SW'(1);
                    end
                    SAMPLE: begin
                        hit_q   <= hit_d;
                        trial_q <= trial_q - CNT_WIDTH'(1);
                        state_q <= CHECK;
                    end
                    CHECK: begin
                        if (trial_q == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= TRIG;
                            trig_q  <= 1'b1;
                        end
                    end
                    DONE: begin
                        for (int c = 0; c < int'(NUM_CH); c++)
                            data_q[c*CNT_WIDTH +: CNT_WIDTH] <= hit_q[c];
                        valid_q <= 1'b1;
                        // A pending, unaccepted result is being replaced
                        if (valid_q && !bus.result_ready) overrun_q <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.trigger_data_out = trig_q;
    assign bus.busy             = busy_q;
    assign bus.result_valid     = valid_q;
    assign bus.result_data      = data_q;
    assign bus.result_overrun   = overrun_q;

endmodule

// File: tb/tb_probe_detector_mc.sv
// Self-checking bench for probe_detector_mc (4 channels, 8-bit counters,
// 2 settle cycles). Inputs are driven and outputs sampled on the falling edge.
module tb_probe_detector_mc;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned ST    = 2;
    localparam int          TRIAL = int'(ST) + 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [7:0]  aver;
        logic [3:0]  probe;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    probe_detector_mc_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) bus ();

    probe_detector_mc #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .SETTLE_CYCLES(ST), .SYNC_STAGES(2)
    ) dut (
        .shifting_clk (clk),
        .shifting_rst (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait on falling edges until result_valid is seen or the budget runs out
    task automatic wait_valid(input int budget, output int waited, output logic seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (bus.result_valid === 1'b1) seen = 1'b1;
        end
    endtask

    // One table vector: run, check trigger spacing, latency, data, then accept
    task automatic run_vec(input int idx);
        int          n, pulses, bad, vidx;
        logic        seen;
        logic [31:0] exp;
        n = (vecs[idx].aver == 8'd0) ? 1 : int'(vecs[idx].aver);
        bus.probe_signal_in = vecs[idx].probe;
        bus.aver_time       = vecs[idx].aver;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        exp_q.push_back(vecs[idx].exp_data);
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0; bad = 0; vidx = -1; seen = 1'b0;
        for (int i = 0; (i <= TRIAL*n + 8) && !seen; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.trigger_data_out === 1'b1) begin
                pulses++;
                if ((i % TRIAL) != 0 || i >= TRIAL*n) bad++;
            end
            if (i <= TRIAL*n && bus.busy !== 1'b1) bad++;
            if (bus.result_valid === 1'b1) begin
                seen = 1'b1;
                vidx = i;
            end
        end
        chk($sformatf("v%0d_valid_seen", idx), 32'(seen), 32'd1);
        // Set by edge k+TRIAL*n+1, so first sampled high at edge k+2+TRIAL*n
        chk($sformatf("v%0d_latency", idx), 32'(vidx), 32'(TRIAL*n + 1));
        chk($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(n));
        chk($sformatf("v%0d_timing_errs", idx), 32'(bad), 32'd0);
        chk($sformatf("v%0d_busy_after", idx), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_overrun", idx), 32'(bus.result_overrun), 32'd0);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk($sformatf("v%0d_data", idx), bus.result_data, exp);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk($sformatf("v%0d_valid_cleared", idx), 32'(bus.result_valid), 32'd0);
    endtask

    initial begin
        int   waited;
        logic seen;
        checks   = 0;
        failures = 0;
        vecs[0] = '{8'd4,   4'b0101, 32'h00040004};
        vecs[1] = '{8'd0,   4'b1111, 32'h01010101};
        vecs[2] = '{8'd255, 4'b1111, 32'hFFFFFFFF};
        vecs[3] = '{8'd3,   4'b1010, 32'h03000300};
        vecs[4] = '{8'd1,   4'b0000, 32'h00000000};
        vecs[5] = '{8'd7,   4'b1000, 32'h07000000};

        rst = 1'b1;
        bus.start = 1'b0; bus.continuous = 1'b0; bus.abort = 1'b0;
        bus.aver_time = '0; bus.probe_signal_in = '0; bus.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_trigger", 32'(bus.trigger_data_out), 32'd0);
        chk("rst_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_overrun", 32'(bus.result_overrun), 32'd0);
        chk("rst_data", bus.result_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) run_vec(v);

        // Abort has priority over start in IDLE
        bus.abort = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("idle_abort_busy", 32'(bus.busy), 32'd0);
        chk("idle_abort_trig", 32'(bus.trigger_data_out), 32'd0);

        // start and aver_time changes while busy do not disturb the run
        bus.probe_signal_in = 4'b0001; bus.aver_time = 8'd2;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.aver_time = 8'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(30, waited, seen);
        chk("midrun_valid_seen", 32'(seen), 32'd1);
        chk("midrun_latency", 32'(waited + 4), 32'(TRIAL*2 + 1));
        chk("midrun_data", bus.result_data, 32'h00000002);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;

        // Continuous runs with no acceptance: second result overwrites, overrun sets
        bus.probe_signal_in = 4'b0011; bus.aver_time = 8'd2; bus.continuous = 1'b1;
        repeat (3) @(negedge clk);
        wait_valid(40, waited, seen);
        chk("ovr_first_seen", 32'(seen), 32'd1);
        chk("ovr_first_data", bus.result_data, 32'h00000202);
        bus.probe_signal_in = 4'b1100;
        @(negedge clk);
        chk("ovr_run2_busy", 32'(bus.busy), 32'd1);
        bus.continuous = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.result_overrun === 1'b1) seen = 1'b1;
        end
        chk("ovr_set", 32'(seen), 32'd1);
        chk("ovr_valid", 32'(bus.result_valid), 32'd1);
        chk("ovr_data", bus.result_data, 32'h02020000);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("ovr_valid_clr", 32'(bus.result_valid), 32'd0);
        chk("ovr_overrun_clr", 32'(bus.result_overrun), 32'd0);
        repeat (15) @(negedge clk);
        chk("ovr_stays_idle", 32'(bus.busy), 32'd0);

        // DONE coincides with acceptance of the pending result
        bus.probe_signal_in = 4'b0011; bus.continuous = 1'b1;
        repeat (3) @(negedge clk);
        wait_valid(40, waited, seen);
        chk("coin_first_seen", 32'(seen), 32'd1);
        bus.probe_signal_in = 4'b1100;
        @(negedge clk);
        chk("coin_run2_trig", 32'(bus.trigger_data_out), 32'd1);
        bus.continuous = 1'b0;
        repeat (TRIAL*2) @(negedge clk);
        chk("coin_pending_data", bus.result_data, 32'h00000202);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("coin_valid", 32'(bus.result_valid), 32'd1);
        chk("coin_data", bus.result_data, 32'h02020000);
        chk("coin_overrun", 32'(bus.result_overrun), 32'd0);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("coin_valid_clr", 32'(bus.result_valid), 32'd0);

        // Abort in the settle window of the second trial
        bus.probe_signal_in = 4'b1111; bus.aver_time = 8'd3;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (TRIAL + 1) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_trig", 32'(bus.trigger_data_out), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_no_valid", 32'(bus.result_valid), 32'd0);
        chk("abort_still_idle", 32'(bus.busy), 32'd0);

        // Reset mid-run with a pending result clears everything
        bus.probe_signal_in = 4'b0001; bus.aver_time = 8'd1;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(20, waited, seen);
        chk("rstmid_pending_seen", 32'(seen), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("rstmid_running", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_valid", 32'(bus.result_valid), 32'd0);
        chk("rstmid_overrun", 32'(bus.result_overrun), 32'd0);
        chk("rstmid_data", bus.result_data, 32'd0);
        chk("rstmid_trig", 32'(bus.trigger_data_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/probe_detector_mc.md
PROBE_DETECTOR_MC -- requirements
Module: probe_detector_mc

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent probe channels (1..32).
REQ-002 SHALL provide parameter CNT_WIDTH, default 16, width of the trial counter and of each channel hit counter (8..24).
REQ-003 SHALL provide parameter SETTLE_CYCLES, default 2, number of idle cycles between trigger and sample (1..15).
REQ-004 SHALL provide parameter SYNC_STAGES, default 2, flip-flops per channel synchronizer (2..4).
REQ-005 SHALL have port shifting_clk  input  1  sole clock; all logic on rising edge; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port shifting_rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  one-shot run request, sampled only in IDLE.
REQ-008 SHALL have port continuous  input  1  when 1, IDLE restarts a run automatically.
REQ-009 SHALL have port abort  input  1  terminates the current run without a result.
REQ-010 SHALL have port aver_time  input  CNT_WIDTH  trials per run, latched at run start.
REQ-011 SHALL have port probe_signal_in  input  NUM_CH  asynchronous probe inputs.
REQ-012 SHALL have port trigger_data_out  output  1  one-cycle trigger pulse per trial.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port result_valid  output  1  result available.
REQ-015 SHALL have port result_ready  input  1  consumer accepts result.
REQ-016 SHALL have port result_data  output  NUM_CH*CNT_WIDTH  channel c hit count at bits [c*CNT_WIDTH +: CNT_WIDTH].
REQ-017 SHALL have port result_overrun  output  1  an unaccepted result was overwritten.

Function
REQ-018 SHALL pass each probe_signal_in bit through SYNC_STAGES flip-flops before use; no other logic touches the raw input.
REQ-019 SHALL implement FSM states IDLE, TRIG, SETTLE, SAMPLE, CHECK, DONE.
REQ-020 IDLE: if start or continuous is 1, SHALL load trial counter with aver_time (0 treated as 1), clear all hit counters, go to TRIG; otherwise stay.
REQ-021 TRIG: SHALL drive trigger_data_out=1 for exactly this cycle, load settle counter, go to SETTLE.
REQ-022 SETTLE: SHALL stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-023 SAMPLE: SHALL add each synchronized channel bit to its hit counter, decrement trial counter, go to CHECK.
REQ-024 CHECK: SHALL go to DONE if trial counter is 0, else to TRIG.
REQ-025 DONE: SHALL copy all hit counters into result_data, set result_valid, go to IDLE.
REQ-026 Each trial SHALL take SETTLE_CYCLES+3 cycles; with start sampled at edge k, result_valid SHALL first be high at edge k+2+N*(SETTLE_CYCLES+3) for N trials.
REQ-027 Hit counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-028 result_valid SHALL stay high and result_data stable until a cycle with result_valid & result_ready, after which result_valid clears.
REQ-029 If DONE occurs while result_valid=1 and result_ready=0, new data SHALL overwrite result_data and result_overrun SHALL set.
REQ-030 If DONE coincides with an accepting handshake, new data SHALL load, result_valid SHALL remain 1, result_overrun SHALL not set.
REQ-031 result_overrun SHALL be sticky, cleared on the next accepting handshake or reset.
REQ-032 start while busy=1 SHALL be ignored; aver_time changes mid-run SHALL not affect the run.
REQ-033 continuous deasserted mid-run SHALL let the current run finish, then remain in IDLE.
REQ-034 abort=1 in any non-IDLE state SHALL return FSM to IDLE next cycle, leaving result_valid/result_data unchanged; abort has priority over start/continuous in IDLE.

Reset
REQ-035 shifting_rst=1 at any edge SHALL force IDLE, trigger_data_out=0, busy=0, result_valid=0, result_overrun=0, result_data=0, all counters and synchronizers 0, overriding all other inputs including mid-run.

Verification
REQ-036 NUM_CH=4, SETTLE=2, aver_time=4, probe=4'b0101 static, start at edge k -> 4 trigger pulses 5 cycles apart, result_valid at k+22, counts {0,4,0,4}.
REQ-037 CNT_WIDTH=8, aver_time=0 then aver_time=255 with probe all-ones -> 1 trial, counts 1; then counts 255, no wrap.
REQ-038 continuous=1, result_ready=0 across two runs -> second DONE overwrites data, result_overrun=1; one ready cycle -> both clear.
REQ-039 DONE in same cycle as result_ready=1 on pending result -> result_valid stays 1, new data, result_overrun=0.
REQ-040 abort during SETTLE of trial 2 -> IDLE next cycle, busy=0, no result_valid; shifting_rst mid-run -> all outputs 0 next cycle.
